fifo_wr_ctrl: RTL and testbench
===============================

FIFO_WR_CTRL -- requirements
Module: fifo_wr_ctrl

Interface
REQ-001 The module SHALL have parameter ADDR_WIDTH, default 4, giving memory address width (depth 2^ADDR_WIDTH = 16 entries).
REQ-002 The module SHALL have parameter AF_THRESH, default 12, giving the occupancy at or above which almost_full asserts; legal range 1..2^ADDR_WIDTH.
REQ-003 wr_clk  input  1  write-domain clock; the block's only clock.
REQ-004 wr_rst  input  1  asynchronous, active-low reset.
REQ-005 wr_en  input  1  write request, sampled on rising wr_clk.
REQ-006 overflow_clr  input  1  synchronous clear of the sticky overflow flag.
REQ-007 rd_ptr_grey  input  ADDR_WIDTH+1  read-domain Gray pointer, asynchronous to wr_clk.
REQ-008 mem_we  output  1  memory write strobe, combinational.
REQ-009 wr_addr_bin  output  ADDR_WIDTH  memory write address, the low bits of the binary write pointer.
REQ-010 wr_addr_grey  output  ADDR_WIDTH+1  registered Gray write pointer, exported to the read domain.
REQ-011 full  output  1  registered FIFO-full flag.
REQ-012 almost_full  output  1  registered occupancy threshold flag.
REQ-013 wr_level  output  ADDR_WIDTH+1  registered write-side occupancy, range 0..2^ADDR_WIDTH.
REQ-014 overflow  output  1  sticky flag marking a write attempted while full.

Function
REQ-015 rd_ptr_grey SHALL pass through a two-flop synchronizer clocked by wr_clk, giving rd_ptr_sync; no other logic SHALL sample rd_ptr_grey.
REQ-016 Write accept: accept = wr_en & !full; mem_we SHALL equal accept in the same cycle.
REQ-017 Binary pointer: wr_bin_next = wr_bin + accept, an (ADDR_WIDTH+1)-bit value that wraps modulo 2^(ADDR_WIDTH+1) (31 -> 0 for the default).
REQ-018 Gray pointer: wr_grey_next = (wr_bin_next >> 1) ^ wr_bin_next; wr_addr_grey SHALL register wr_grey_next each cycle.
REQ-019 wr_addr_bin SHALL equal wr_bin[ADDR_WIDTH-1:0] and update one cycle after an accepted write.
REQ-020 Full: full SHALL register (wr_grey_next == {~rd_ptr_sync[MSB:MSB-1], rd_ptr_sync[MSB-2:0]}).
REQ-021 Level: rd_ptr_sync SHALL be Gray-to-binary converted to rd_bin_sync; wr_level SHALL register (wr_bin_next - rd_bin_sync) modulo 2^(ADDR_WIDTH+1).
REQ-022 almost_full SHALL register (level_next >= AF_THRESH); it SHALL update in the same cycle as wr_level.
REQ-023 Overflow: overflow SHALL set on the clock edge following any cycle with wr_en & full, and SHALL clear on a cycle with overflow_clr & !(wr_en & full). When set and clear coincide, set SHALL win.
REQ-024 A write attempted while full SHALL NOT advance any pointer and SHALL NOT assert mem_we.
REQ-025 Read-side frees SHALL become visible to full, wr_level and almost_full no earlier than 3 wr_clk edges after rd_ptr_grey changes (2 synchronizer stages plus the flag register). Write-side updates SHALL take effect one edge after the accepted write.
REQ-026 full and wr_level SHALL be pessimistic only: stale rd_ptr_sync may overstate occupancy but SHALL never understate it.
REQ-027 wr_addr_grey SHALL change by at most one bit per wr_clk cycle.

Reset
REQ-028 While wr_rst = 0, the following SHALL be 0: wr_bin, wr_addr_bin, wr_addr_grey, both synchronizer stages, full, almost_full, wr_level and overflow.
REQ-029 Assertion of wr_rst SHALL take effect immediately, regardless of wr_clk, including mid-burst or while full.
REQ-030 After reset deassertion, the first write SHALL be accepted on the first rising edge with wr_en = 1.

Verification
REQ-031 Reset, rd_ptr_grey = 0, then 16 consecutive wr_en cycles -> mem_we high 16 cycles; wr_addr_bin steps 0..15; full = 1 after the 16th edge; wr_level = 16; wr_addr_grey = 5'b11000.
REQ-032 At full, assert wr_en 2 more cycles -> mem_we = 0; pointers hold; overflow = 1 and stays 1; overflow_clr pulse with wr_en = 0 -> overflow = 0 next edge.
REQ-033 At full, change rd_ptr_grey 0 -> 00001 -> full stays 1 for 2 edges, then deasserts on the 3rd edge; wr_level = 15; almost_full still 1.
REQ-034 Fill to 11 entries -> almost_full = 0; 12th write -> almost_full = 1 on the same edge that wr_level = 12.
REQ-035 Wrap: run a continuous write/read stream of 40 writes with rd_ptr_grey tracking 4 entries behind -> wr_addr_grey passes 10000 (bin 31 -> 0 wrap) with one bit change per step; full never asserts; wr_level steady at 4 (±2-cycle sync lag).
REQ-036 Assert wr_rst asynchronously mid-burst at level 9 with overflow = 1 -> all outputs 0 before the next wr_clk edge; resume writes -> wr_addr_bin starts at 0.

Source files
------------

// File: rtl/fifo_wr_ctrl.sv
// rtl/fifo_wr_ctrl.sv - async FIFO write-side controller: pointers, full/level flags, sticky overflow
module fifo_wr_ctrl #(
  parameter int ADDR_WIDTH = 4,
  parameter int AF_THRESH  = 12
) (
  input  logic                  wr_clk,
  input  logic                  wr_rst,
  input  logic                  wr_en,
  input  logic                  overflow_clr,
  input  logic [ADDR_WIDTH:0]   rd_ptr_grey,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] wr_addr_bin,
  output logic [ADDR_WIDTH:0]   wr_addr_grey,
  output logic                  full,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   wr_level,
  output logic                  overflow
);

  localparam logic [ADDR_WIDTH:0] AF_T = (ADDR_WIDTH+1)'(AF_THRESH);

  logic [ADDR_WIDTH:0] rd_sync1_q, rd_ptr_sync_q;
  logic [ADDR_WIDTH:0] wr_bin_q, wr_grey_q, level_q;
  logic                full_q, af_q, ovf_q;

  logic                accept;
  logic [ADDR_WIDTH:0] wr_bin_d, wr_grey_d, rd_bin_sync, level_d, full_cmp;
  logic                full_d, af_d, ovf_d;

  assign accept    = wr_en & ~full_q;
  assign wr_bin_d  = wr_bin_q + {{ADDR_WIDTH{1'b0}}, accept};
  assign wr_grey_d = (wr_bin_d >> 1) ^ wr_bin_d;

  // Full when the write pointer is one lap ahead of the synchronized read pointer.
  assign full_cmp  = {~rd_ptr_sync_q[ADDR_WIDTH:ADDR_WIDTH-1], rd_ptr_sync_q[ADDR_WIDTH-2:0]};
  assign full_d    = (wr_grey_d == full_cmp);

  always_comb begin
    rd_bin_sync = '0;
    for (int i = 0; i <= ADDR_WIDTH; i++) begin
      rd_bin_sync[i] = ^(rd_ptr_sync_q >> i);
    end
  end

  assign level_d = wr_bin_d - rd_bin_sync;
  assign af_d    = (level_d >= AF_T);
  assign ovf_d   = (wr_en & full_q) ? 1'b1 : (overflow_clr ? 1'b0 : ovf_q);

  always_ff @(posedge wr_clk or negedge wr_rst) begin
    if (!wr_rst) begin
      rd_sync1_q    <= '0;
      rd_ptr_sync_q <= '0;
      wr_bin_q      <= '0;
      wr_grey_q     <= '0;
      level_q       <= '0;
      full_q        <= 1'b0;
      af_q          <= 1'b0;
      ovf_q         <= 1'b0;
    end else begin
      rd_sync1_q    <= rd_ptr_grey;
      rd_ptr_sync_q <= rd_sync1_q;
      wr_bin_q      <= wr_bin_d;
      wr_grey_q     <= wr_grey_d;
      level_q       <= level_d;
      full_q        <= full_d;
      af_q          <= af_d;
      ovf_q         <= ovf_d;
    end
  end

  assign mem_we       = accept;
  assign wr_addr_bin  = wr_bin_q[ADDR_WIDTH-1:0];
  assign wr_addr_grey = wr_grey_q;
  assign full         = full_q;
  assign almost_full  = af_q;
  assign wr_level     = level_q;
  assign overflow     = ovf_q;

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// tb/tb_fifo_wr_ctrl.sv - directed scoreboard bench for fifo_wr_ctrl
module tb_fifo_wr_ctrl;

  logic       wr_clk = 1'b0;
  logic       wr_rst = 1'b0;
  logic       wr_en = 1'b0;
  logic       overflow_clr = 1'b0;
  logic [4:0] rd_ptr_grey = '0;
  logic       mem_we;
  logic [3:0] wr_addr_bin;
  logic [4:0] wr_addr_grey;
  logic       full;
  logic       almost_full;
  logic [4:0] wr_level;
  logic       overflow;

  fifo_wr_ctrl #(.ADDR_WIDTH(4), .AF_THRESH(12)) dut (
    .wr_clk(wr_clk), .wr_rst(wr_rst), .wr_en(wr_en), .overflow_clr(overflow_clr),
    .rd_ptr_grey(rd_ptr_grey), .mem_we(mem_we), .wr_addr_bin(wr_addr_bin),
    .wr_addr_grey(wr_addr_grey), .full(full), .almost_full(almost_full),
    .wr_level(wr_level), .overflow(overflow)
  );

  always #5 wr_clk = ~wr_clk;

  int errors = 0;
  int checks = 0;

  // Reference model: binary occupancy counting with a 2-stage lagged read count.
  logic [4:0] m_bin, m_lvl, m_s1, m_s2, rd_cnt;
  logic       m_full, m_af, m_ovf;
  logic [3:0] sb[$];
  logic       seen_wrap;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_bin = '0; m_lvl = '0; m_s1 = '0; m_s2 = '0; rd_cnt = '0;
    m_full = 1'b0; m_af = 1'b0; m_ovf = 1'b0;
    sb.delete();
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_mem_we"}, mem_we, 0);
    chk({tag, "_addr"}, wr_addr_bin, 0);
    chk({tag, "_grey"}, wr_addr_grey, 0);
    chk({tag, "_full"}, full, 0);
    chk({tag, "_af"}, almost_full, 0);
    chk({tag, "_level"}, wr_level, 0);
    chk({tag, "_ovf"}, overflow, 0);
  endtask

  // Called #1 after a rising edge: drive, check combinational outputs at the falling edge, then clock.
  task automatic step(input logic we, input logic clr);
    logic       acc;
    logic [4:0] bin_n, lvl_n, prev_grey;
    wr_en = we;
    overflow_clr = clr;
    rd_ptr_grey = rd_cnt ^ (rd_cnt >> 1);
    acc = we & ~m_full;
    if (acc) sb.push_back(m_bin[3:0]);
    @(negedge wr_clk);
    chk("mem_we", mem_we, acc);
    if (mem_we === 1'b1) begin
      chk("sb_nonempty", sb.size() != 0, 1);
      if (sb.size() != 0) chk("wr_addr_at_we", wr_addr_bin, sb.pop_front());
    end
    bin_n = m_bin + 5'(acc);
    lvl_n = bin_n - m_s2;
    m_ovf = (we & m_full) ? 1'b1 : (clr ? 1'b0 : m_ovf);
    m_full = (lvl_n == 5'd16);
    m_af = (lvl_n >= 5'd12);
    m_lvl = lvl_n;
    m_bin = bin_n;
    m_s2 = m_s1;
    m_s1 = rd_cnt;
    prev_grey = wr_addr_grey;
    @(posedge wr_clk);
    #1;
    chk("grey_one_bit", $countones(prev_grey ^ wr_addr_grey) <= 1, 1);
    chk("wr_addr_bin", wr_addr_bin, m_bin[3:0]);
    chk("wr_addr_grey", wr_addr_grey, m_bin ^ (m_bin >> 1));
    chk("full", full, m_full);
    chk("almost_full", almost_full, m_af);
    chk("wr_level", wr_level, m_lvl);
    chk("overflow", overflow, m_ovf);
    if (wr_addr_grey === 5'b10000) seen_wrap = 1'b1;
  endtask

  task automatic do_reset();
    wr_en = 1'b0;
    overflow_clr = 1'b0;
    wr_rst = 1'b0;
    model_reset();
    rd_ptr_grey = '0;
    @(posedge wr_clk);
    #1;
    check_all_zero("rst");
    wr_rst = 1'b1;
  endtask

  initial begin
    seen_wrap = 1'b0;
    model_reset();
    #2;
    check_all_zero("por");
    @(posedge wr_clk);
    #1;
    wr_rst = 1'b1;

    // Fill 16 entries from empty.
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0);
    chk("fill_full", full, 1);
    chk("fill_level", wr_level, 16);
    chk("fill_grey", wr_addr_grey, 5'b11000);

    // Writes at full are dropped and set the sticky overflow.
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    chk("ovf_set", overflow, 1);
    chk("ovf_ptr_hold", wr_addr_grey, 5'b11000);
    step(1'b0, 1'b0);
    chk("ovf_sticky", overflow, 1);
    step(1'b0, 1'b1);
    chk("ovf_clr", overflow, 0);
    step(1'b1, 1'b1);
    chk("ovf_set_wins", overflow, 1);
    step(1'b0, 1'b1);

    // One read freed: visible only on the third edge.
    rd_cnt = 5'd1;
    step(1'b0, 1'b0);
    chk("rd_lag1_full", full, 1);
    step(1'b0, 1'b0);
    chk("rd_lag2_full", full, 1);
    step(1'b0, 1'b0);
    chk("rd_lag3_full", full, 0);
    chk("rd_lag3_level", wr_level, 15);
    chk("rd_lag3_af", almost_full, 1);

    // almost_full threshold boundary.
    do_reset();
    for (int i = 0; i < 11; i++) step(1'b1, 1'b0);
    chk("af_11", almost_full, 0);
    chk("lvl_11", wr_level, 11);
    step(1'b1, 1'b0);
    chk("af_12", almost_full, 1);
    chk("lvl_12", wr_level, 12);

    // Continuous stream with reader 4 behind; pointer wraps 31 -> 0.
    do_reset();
    seen_wrap = 1'b0;
    for (int w = 0; w < 40; w++) begin
      rd_cnt = 5'((w >= 4) ? w - 4 : 0);
      step(1'b1, 1'b0);
      chk("stream_no_full", full, 0);
    end
    chk("stream_wrap_seen", seen_wrap, 1);

    // Async reset mid-burst at level 9 with overflow set.
    do_reset();
    for (int i = 0; i < 17; i++) step(1'b1, 1'b0);
    rd_cnt = 5'd7;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
    chk("pre_rst_level", wr_level, 9);
    chk("pre_rst_ovf", overflow, 1);
    wr_en = 1'b1;
    #3;
    wr_rst = 1'b0;
    wr_en = 1'b0;
    #1;
    check_all_zero("async_rst");
    model_reset();
    rd_ptr_grey = '0;
    @(posedge wr_clk);
    #1;
    check_all_zero("async_rst_hold");
    wr_rst = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
    chk("resume_addr", wr_addr_bin, 3);
    chk("sb_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
